// File: rtl/pending_priority_encoder.sv
// pending_priority_encoder: latched events, highest index presented on valid/ready; define PRIO_ENC_MASK_EN to add a mask port
module pending_priority_encoder #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] req,
`ifdef PRIO_ENC_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  input  logic             clr_all,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] pending,
  output logic             overflow
);
  logic hs, load;
  logic [WIDTH-1:0] clr_bit, cand, elig;
  logic [IDX_W-1:0] top;
  always_comb begin
    hs = out_valid & out_ready;
    clr_bit = hs ? WIDTH'(1) << out_idx : '0;
    cand = pending & ~clr_bit;
`ifdef PRIO_ENC_MASK_EN
    elig = cand & ~mask;
`else
    elig = cand;
`endif
    load = (!out_valid | out_ready) & enable & !clr_all;
    top = out_idx;
    for (int i = 0; i < WIDTH; i++) if (elig[i]) top = IDX_W'(i);
  end
  // a req landing on the index being accepted is a fresh event, not a loss
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      overflow <= 1'b0;
      out_valid <= 1'b0;
      out_idx <= '0;
    end else begin
      pending <= clr_all ? '0 : cand | (enable ? req : '0);
      overflow <= clr_all ? 1'b0 : overflow | (enable & |(req & cand));
      out_valid <= clr_all ? 1'b0 : load ? |elig : out_valid & !hs;
      if (load) out_idx <= top;
    end
endmodule

// File: tb/tb_pending_priority_encoder.sv
// tb_pending_priority_encoder: directed vectors against hand-computed values, WIDTH=8 and WIDTH=5
module tb_pending_priority_encoder;
  logic clk = 0, rst_n = 0;
  logic en = 1, clr = 0, rdy = 0;
  logic [7:0] req = 0;
  logic vld;
  logic [2:0] idx;
  logic [7:0] pend;
  logic ovf;
  logic en5 = 1, clr5 = 0, rdy5 = 0;
  logic [4:0] req5 = 0;
  logic vld5;
  logic [2:0] idx5;
  logic [4:0] pend5;
  logic ovf5;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  pending_priority_encoder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .enable(en), .req(req), .clr_all(clr),
    .out_valid(vld), .out_ready(rdy), .out_idx(idx), .pending(pend), .overflow(ovf));

  pending_priority_encoder #(.WIDTH(5)) u5 (
    .clk(clk), .rst_n(rst_n), .enable(en5), .req(req5), .clr_all(clr5),
    .out_valid(vld5), .out_ready(rdy5), .out_idx(idx5), .pending(pend5), .overflow(ovf5));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    check("rst_pend", pend, 0);
    check("rst_vld", vld, 0);
    check("rst_idx", idx, 0);
    check("rst_ovf", ovf, 0);
    #9 rst_n = 1;
    tick();
    // single event, held output
    req = 8'h10; tick(); req = 0;
    check("s_pend", pend, 8'h10);
    check("s_vld0", vld, 0);
    tick();
    check("s_vld", vld, 1);
    check("s_idx", idx, 4);
    tick(); tick();
    check("s_hold_idx", idx, 4);
    check("s_hold_vld", vld, 1);
    rdy = 1; tick(); rdy = 0;
    check("s_acc_pend", pend, 0);
    check("s_acc_vld", vld, 0);
    // descending drain
    req = 8'b1010_0101; tick(); req = 0; rdy = 1;
    tick(); check("d_7", idx, 7); check("d_v7", vld, 1);
    tick(); check("d_5", idx, 5);
    tick(); check("d_2", idx, 2);
    tick(); check("d_0", idx, 0); check("d_v0", vld, 1);
    tick(); check("d_end", vld, 0);
    rdy = 0;
    // no preemption
    req = 8'h02; tick(); req = 0; tick();
    check("np_idx1", idx, 1);
    req = 8'h40; tick(); req = 0;
    check("np_hold", idx, 1);
    check("np_pend", pend, 8'h42);
    tick();
    check("np_hold2", idx, 1);
    rdy = 1; tick();
    check("np_next", idx, 6);
    check("np_vld", vld, 1);
    tick(); rdy = 0;
    check("np_empty", vld, 0);
    // overflow: repeat while pending
    req = 8'h08; tick(); tick(); req = 0;
    check("ov_set", ovf, 1);
    tick();
    check("ov_sticky", ovf, 1);
    check("ov_idx", idx, 3);
    clr = 1; tick(); clr = 0;
    check("ov_clr", ovf, 0);
    check("ov_clr_pend", pend, 0);
    // same-cycle re-request on the accepted index
    req = 8'h08; tick(); req = 0; tick();
    check("rr_idx", idx, 3);
    rdy = 1; req = 8'h08; tick(); req = 0; rdy = 0;
    check("rr_pend", pend, 8'h08);
    check("rr_ovf", ovf, 0);
    check("rr_gap", vld, 0);
    tick();
    check("rr_vld", vld, 1);
    check("rr_idx2", idx, 3);
    clr = 1; tick(); clr = 0;
    // enable low
    req = 8'h04; tick(); req = 0; tick();
    en = 0; req = 8'hFF; tick(); req = 0;
    check("en_pend", pend, 8'h04);
    check("en_vld", vld, 1);
    rdy = 1; tick(); rdy = 0;
    check("en_acc_vld", vld, 0);
    check("en_acc_pend", pend, 0);
    tick();
    check("en_noload", vld, 0);
    en = 1;
    // clr_all beats req
    req = 8'h80; tick(); tick(); req = 0; tick();
    check("cl_pre_ovf", ovf, 1);
    clr = 1; req = 8'h01; tick(); clr = 0; req = 0;
    check("cl_pend", pend, 0);
    check("cl_vld", vld, 0);
    check("cl_ovf", ovf, 0);
    // non-power-of-two width
    req5 = 5'b10000; tick(); req5 = 0; tick();
    check("w5_vld", vld5, 1);
    check("w5_idx", idx5, 4);
    // asynchronous reset mid-cycle
    req = 8'hFF; tick(); tick(); req = 0;
    check("ar_pre", pend, 8'hFF);
    #2 rst_n = 0;
    #1;
    check("ar_pend", pend, 0);
    check("ar_vld", vld, 0);
    check("ar_idx", idx, 0);
    check("ar_ovf", ovf, 0);
    check("ar_pend5", pend5, 0);
    #2 rst_n = 1;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
